// File: rtl/space_pkg.sv
// -----------------------------------------------------------------------------
// space_pkg
// Shared constants and types for the space-shooter datapath blocks.
//   FIXED_POINT_MULTIPLIER / FP_SHIFT : fixed-point position scaling (1/64 px)
//   coord_t                           : signed 11-bit screen coordinate
//   SCREEN_W / SCREEN_H               : visible screen size in pixels
// -----------------------------------------------------------------------------
package space_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/player_missile_launcher_if.sv
// -----------------------------------------------------------------------------
// player_missile_launcher_if
// Bundles the launcher's frame/keyboard/player-position inputs and its
// per-slot missile outputs.
//   master : drives startOfFrame, fireReq, playerX/Y, collision;
//            observes topLeftX/Y, activeMask, fireAck, shotsFired
//   slave  : the launcher itself (opposite directions)
// -----------------------------------------------------------------------------
interface player_missile_launcher_if
    import space_pkg::*;
#(
    parameter int NUM_SHOTS = 4
);

    logic                 startOfFrame;
    logic                 fireReq;
    logic [10:0]          playerX;
    logic [10:0]          playerY;
    logic [NUM_SHOTS-1:0] collision;

    coord_t               topLeftX [NUM_SHOTS];
    coord_t               topLeftY [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] activeMask;
    logic                 fireAck;
    logic [7:0]           shotsFired;

    modport master (
        output startOfFrame, fireReq, playerX, playerY, collision,
        input  topLeftX, topLeftY, activeMask, fireAck, shotsFired
    );

    modport slave (
        input  startOfFrame, fireReq, playerX, playerY, collision,
        output topLeftX, topLeftY, activeMask, fireAck, shotsFired
    );

endinterface

// File: rtl/player_missile_launcher_missile_slot.sv
// -----------------------------------------------------------------------------
// missile_slot
// Trajectory state of one player missile: fixed-point X/Y and an active flag.
//   clk, resetN : clock, asynchronous active-low reset
//   load        : take loadX/loadY as new position and become active
//   loadX/loadY : launch position, 32-bit signed fixed point (1/64 px)
//   step        : once-per-frame motion strobe (startOfFrame)
//   hit         : collision pulse for this slot
//   X, Y        : pixel position (fixed point >>> 6, truncated to 11 bits)
//   active      : slot currently in flight
// Priority each cycle: load, then hit, then step. A hit on an inactive slot
// (including one being loaded in the same cycle) has no effect.
// -----------------------------------------------------------------------------
module missile_slot
    import space_pkg::*;
#(
    parameter int Y_SPEED     = 256,
    parameter int TOP_LIMIT_Y = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic signed [31:0] loadX,
    input  logic signed [31:0] loadY,
    input  logic               step,
    input  logic               hit,
    output coord_t             X,
    output coord_t             Y,
    output logic               active
);

    localparam logic signed [31:0] TOP_LIMIT_FP = 32'(TOP_LIMIT_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] SPEED_FP     = 32'(Y_SPEED);

    logic signed [31:0] x_fp;
    logic signed [31:0] y_fp;

    // Pixel coordinate from fixed point: arithmetic shift keeps the sign,
    // then only the low 11 bits are kept.
    function automatic coord_t fp_to_coord(input logic signed [31:0] fp);
        logic signed [31:0] shifted;
        shifted = fp >>> FP_SHIFT;
        return coord_t'(shifted);
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_fp   <= '0;
            y_fp   <= '0;
            active <= 1'b0;
        end else if (load) begin
            x_fp   <= loadX;
            y_fp   <= loadY;
            active <= 1'b1;
        end else if (hit && active) begin
            active <= 1'b0;
        end else if (step && active) begin
            // Retirement is decided on the pre-update Y; a retiring
            // missile keeps its last position.
            if (y_fp < TOP_LIMIT_FP) begin
                active <= 1'b0;
            end else begin
                y_fp <= y_fp - SPEED_FP;
            end
        end
    end

    assign X = fp_to_coord(x_fp);
    assign Y = fp_to_coord(y_fp);

endmodule

// File: rtl/player_missile_launcher.sv
// -----------------------------------------------------------------------------
// player_missile_launcher
// Owns the pool of upward-travelling player missiles: turns a fire key press
// into one launched missile, moves missiles each frame and retires them on
// collision or at the top of the screen.
//   clk, resetN : clock, asynchronous active-low reset
//   bus.startOfFrame : 1-cycle frame strobe
//   bus.fireReq      : fire key level
//   bus.playerX/Y    : player top-left position (px)
//   bus.collision    : per-slot hit pulses
//   bus.topLeftX/Y   : per-slot missile position (px, signed)
//   bus.activeMask   : per-slot in-flight flags
//   bus.fireAck      : 1-cycle pulse the cycle after a launch frame strobe
//   bus.shotsFired   : wrapping launch counter
// -----------------------------------------------------------------------------
module player_missile_launcher
    import space_pkg::*;
#(
    parameter int NUM_SHOTS       = 4,
    parameter int Y_SPEED         = 256,
    parameter int TOP_LIMIT_Y     = 8,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int X_OFFSET        = 14
) (
    input logic                      clk,
    input logic                      resetN,
    player_missile_launcher_if.slave bus
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 2);

    logic                 fireReq_d;
    logic                 pending;
    logic [CD_W-1:0]      cooldown;
    logic [NUM_SHOTS-1:0] active;
    logic [NUM_SHOTS-1:0] load_sel;
    logic                 free_any;
    logic                 fire_rise;
    logic                 cd_zero;
    logic                 launch;
    logic signed [31:0]   load_x_fp;
    logic signed [31:0]   load_y_fp;

    assign fire_rise = bus.fireReq & ~fireReq_d;
    assign cd_zero   = (cooldown == '0);
    assign launch    = bus.startOfFrame & pending & cd_zero & free_any;

    // Launch position in fixed point; playerX/Y are unsigned pixels.
    assign load_x_fp = ($signed({21'd0, bus.playerX}) + 32'(X_OFFSET)) * 32'(FIXED_POINT_MULTIPLIER);
    assign load_y_fp = $signed({21'd0, bus.playerY}) * 32'(FIXED_POINT_MULTIPLIER);

    // Lowest-index inactive slot, one-hot.
    always_comb begin
        load_sel = '0;
        free_any = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!active[i] && !free_any) begin
                load_sel[i] = 1'b1;
                free_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fireReq_d <= 1'b0;
        end else begin
            fireReq_d <= bus.fireReq;
        end
    end

    // A fresh press always arms; otherwise a frame strobe with the cooldown
    // expired consumes the request, whether it launched or found no slot.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending <= 1'b0;
        end else if (fire_rise) begin
            pending <= 1'b1;
        end else if (bus.startOfFrame && pending && cd_zero) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown <= '0;
        end else if (launch) begin
            cooldown <= CD_W'(COOLDOWN_FRAMES);
        end else if (bus.startOfFrame && !cd_zero) begin
            cooldown <= cooldown - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.fireAck    <= 1'b0;
            bus.shotsFired <= '0;
        end else begin
            bus.fireAck <= launch;
            if (launch) begin
                bus.shotsFired <= bus.shotsFired + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        missile_slot #(
            .Y_SPEED     (Y_SPEED),
            .TOP_LIMIT_Y (TOP_LIMIT_Y)
        ) u_slot (
            .clk    (clk),
            .resetN (resetN),
            .load   (launch & load_sel[g]),
            .loadX  (load_x_fp),
            .loadY  (load_y_fp),
            .step   (bus.startOfFrame),
            .hit    (bus.collision[g]),
            .X      (bus.topLeftX[g]),
            .Y      (bus.topLeftY[g]),
            .active (active[g])
        );
    end

    assign bus.activeMask = active;

endmodule
